// File: rtl/cdb_arbiter_pkg.sv
// Helpers local to the CDB arbiter.
package cdb_arbiter_pkg;

    // Round-robin successor of index idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/data_types.sv
// Shared datapath types for the tag/value common data bus.
package data_types;

    // Producing reservation-station / unit tag; NO_VAL marks an empty bus slot.
    typedef enum logic [3:0] {
        NO_VAL = 4'd0,
        ALU_1,
        ALU_2,
        ALU_3,
        ALU_4,
        MUL_1,
        MUL_2,
        LD_1,
        LD_2,
        ST_1,
        ST_2
    } rs_tag_t;

    typedef logic [31:0] word32_t;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;

    // Number of result sources at the top-level CDB arbiter instance.
    localparam int unsigned NUM_CDB_REQ = 4;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    // One extra bit so ptr+k can exceed NUM_REQ-1 before the wrap subtraction.
    logic [IdxW:0] pos;

    // Walk upward from the pointer and take the first requester.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr_i} + (IdxW + 1)'(k);
            if (pos >= (IdxW + 1)'(NUM_REQ)) begin
                pos = pos - (IdxW + 1)'(NUM_REQ);
            end
            if (!valid_o && req_i[pos[IdxW-1:0]]) begin
                valid_o                 = 1'b1;
                gnt_o[pos[IdxW-1:0]]    = 1'b1;
                idx_o                   = pos[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a one-entry holding register per result source.
module cdb_arbiter
    import data_types::*;
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_CDB_REQ
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic    [NUM_REQ-1:0]  req_valid_i,
    input  rs_tag_t [NUM_REQ-1:0]  req_tag_i,
    input  word32_t [NUM_REQ-1:0]  req_val_i,
    output logic    [NUM_REQ-1:0]  req_ready_o,
    output logic    [NUM_REQ-1:0]  buf_full_o,
    output logic    [NUM_REQ-1:0]  grant_o,
    output cdb_t                   cdb_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic    [NUM_REQ-1:0] full_q, full_d;
    rs_tag_t [NUM_REQ-1:0] tag_q, tag_d;
    word32_t [NUM_REQ-1:0] val_q, val_d;
    logic    [IdxW-1:0]    ptr_q, ptr_d;
    cdb_t                  cdb_q, cdb_d;

    logic    [NUM_REQ-1:0] gnt;
    logic    [IdxW-1:0]    win_idx;
    logic                  any_gnt;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (full_q),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (win_idx),
        .valid_o (any_gnt)
    );

    // A granted entry drains this edge, so it can accept a refill in the same cycle.
    assign req_ready_o = ~full_q | gnt;
    assign buf_full_o  = full_q;
    assign grant_o     = gnt;
    assign cdb_o       = cdb_q;

    // Holding-register next state: flush beats refill beats drain.
    always_comb begin
        full_d = full_q;
        tag_d  = tag_q;
        val_d  = val_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (flush_i) begin
                full_d[i] = 1'b0;
            end else if (req_valid_i[i] && req_ready_o[i] && (req_tag_i[i] != NO_VAL)) begin
                full_d[i] = 1'b1;
                tag_d[i]  = req_tag_i[i];
                val_d[i]  = req_val_i[i];
            end else if (gnt[i]) begin
                full_d[i] = 1'b0;
            end
        end
    end

    // Broadcast the winner and advance the pointer past it; idle cycles send NO_VAL.
    always_comb begin
        ptr_d     = ptr_q;
        cdb_d.tag = NO_VAL;
        cdb_d.val = '0;
        if (any_gnt) begin
            ptr_d     = IdxW'(rr_next(32'(win_idx), NUM_REQ));
            cdb_d.tag = tag_q[win_idx];
            cdb_d.val = val_q[win_idx];
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_q    <= '0;
            ptr_q     <= '0;
            cdb_q.tag <= NO_VAL;
            cdb_q.val <= '0;
            val_q     <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                tag_q[i] <= NO_VAL;
            end
        end else begin
            full_q <= full_d;
            ptr_q  <= ptr_d;
            cdb_q  <= cdb_d;
            tag_q  <= tag_d;
            val_q  <= val_d;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic vs a model.
module tb_cdb_arbiter;
    import data_types::*;

    localparam int N = NUM_CDB_REQ;

    logic                clk = 1'b0;
    logic                reset_i;
    logic                flush_i;
    logic    [N-1:0]     req_valid;
    rs_tag_t [N-1:0]     req_tag;
    word32_t [N-1:0]     req_val;
    logic    [N-1:0]     ready;
    logic    [N-1:0]     bfull;
    logic    [N-1:0]     grant;
    cdb_t                cdb;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid),
        .req_tag_i   (req_tag),
        .req_val_i   (req_val),
        .req_ready_o (ready),
        .buf_full_o  (bfull),
        .grant_o     (grant),
        .cdb_o       (cdb)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: per-source slots, a rotating priority start, and the last broadcast.
    bit      m_full [N];
    rs_tag_t m_tag  [N];
    word32_t m_val  [N];
    int      m_ptr;
    rs_tag_t m_ctag;
    word32_t m_cval;
    int      dut_age [N];

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i]  = 1'b0;
            m_tag[i]   = NO_VAL;
            m_val[i]   = '0;
            dut_age[i] = 0;
        end
        m_ptr  = 0;
        m_ctag = NO_VAL;
        m_cval = '0;
    endtask

    // Winner is the full slot with the smallest circular distance from the pointer.
    function automatic int m_winner();
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (m_full[i]) begin
                int d = (i - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // One clock: check state-derived outputs, take the edge, update model, check broadcast.
    task automatic tick();
        int              w;
        logic [N-1:0]    eg, er, ef;
        logic [N-1:0]    v;
        rs_tag_t [N-1:0] t;
        word32_t [N-1:0] vv;
        logic            f, r;
        #1;
        w  = m_winner();
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        for (int i = 0; i < N; i++) begin
            ef[i] = m_full[i];
            er[i] = !m_full[i] || (i == w);
        end
        check("grant", 64'(grant), 64'(eg));
        check("ready", 64'(ready), 64'(er));
        check("buf_full", 64'(bfull), 64'(ef));
        for (int i = 0; i < N; i++) begin
            if (bfull[i] && grant[i]) check("starve", 64'(dut_age[i] < N), 64'(1));
        end
        v = req_valid; t = req_tag; vv = req_val; f = flush_i; r = reset_i;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            dut_age[i] = (bfull[i] && !grant[i] && !r) ? dut_age[i] + 1 : 0;
        end
        if (r) begin
            m_reset();
        end else begin
            if (w >= 0) begin
                m_ctag = m_tag[w];
                m_cval = m_val[w];
                m_ptr  = (w + 1) % N;
            end else begin
                m_ctag = NO_VAL;
                m_cval = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (f) begin
                    m_full[i] = 1'b0;
                end else if (v[i] && er[i] && t[i] != NO_VAL) begin
                    m_full[i] = 1'b1;
                    m_tag[i]  = t[i];
                    m_val[i]  = vv[i];
                end else if (i == w) begin
                    m_full[i] = 1'b0;
                end
            end
        end
        #1;
        check("cdb_tag", 64'(cdb.tag), 64'(m_ctag));
        check("cdb_val", 64'(cdb.val), 64'(m_cval));
    endtask

    task automatic idle_inputs();
        flush_i   = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_tag[i] = NO_VAL;
            req_val[i] = '0;
        end
    endtask

    task automatic offer(input int src, input rs_tag_t tg, input word32_t vl);
        req_valid[src] = 1'b1;
        req_tag[src]   = tg;
        req_val[src]   = vl;
    endtask

    // From idle: one broadcast from the last source leaves the pointer at 0.
    task automatic set_ptr0();
        offer(N - 1, ST_2, 32'h55);
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        reset_i = 1'b1;
        idle_inputs();
        m_reset();

        // Reset and idle
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_cdb_tag", 64'(cdb.tag), 64'(NO_VAL));
            check("rst_ready", 64'(ready), 64'({N{1'b1}}));
        end
        reset_i = 1'b0;
        for (int c = 0; c < 3; c++) tick();

        // Single result from source 1
        offer(1, ALU_3, -32'sd5);
        tick();
        idle_inputs();
        #1;
        check("single_full", 64'(bfull[1]), 64'(1));
        check("single_grant", 64'(grant), 64'(4'b0010));
        tick();
        check("single_cdb", 64'(cdb), 64'({ALU_3, 32'hFFFF_FFFB}));
        tick();
        check("single_after", 64'(cdb.tag), 64'(NO_VAL));

        // Contention: all four at once from ptr 0, then refill 3 and 0
        set_ptr0();
        for (int i = 0; i < N; i++) offer(i, rs_tag_t'(i + 1), word32_t'(100 + i));
        tick();
        idle_inputs();
        for (int k = 0; k < N; k++) begin
            rs_tag_t et;
            et = rs_tag_t'(k + 1);
            tick();
            check("rr_order", 64'(cdb.tag), 64'(et));
        end
        offer(0, MUL_1, 32'd200);
        offer(3, MUL_2, 32'd203);
        tick();
        idle_inputs();
        tick();
        check("refill_first", 64'(cdb.tag), 64'(MUL_1));
        tick();
        check("refill_second", 64'(cdb.tag), 64'(MUL_2));
        tick();

        // Backpressure: source 0 streams while source 2 stays full
        for (int c = 0; c < 10; c++) begin
            offer(0, ALU_1, word32_t'(1000 + c));
            offer(2, LD_1, word32_t'(2000 + c));
            if (c >= 1) begin
                #1;
                check("bp_ready0", 64'(ready[0]), 64'(c % 2 == 1));
            end
            tick();
            if (c >= 1) check("bp_alt", 64'(cdb.tag), 64'((c % 2 == 1) ? ALU_1 : LD_1));
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) tick();

        // NO_VAL offer is acknowledged but not stored
        offer(3, NO_VAL, 32'd7);
        #1;
        check("noval_ready", 64'(ready[3]), 64'(1));
        tick();
        idle_inputs();
        check("noval_full", 64'(bfull[3]), 64'(0));
        tick();
        check("noval_cdb", 64'(cdb.tag), 64'(NO_VAL));

        // Flush keeps the committed winner, drops everything else
        set_ptr0();
        offer(0, LD_1, 32'd10);
        offer(1, LD_2, 32'd11);
        offer(2, ST_1, 32'd12);
        tick();
        idle_inputs();
        flush_i = 1'b1;
        offer(1, ALU_2, 32'd99);
        tick();
        idle_inputs();
        check("flush_cdb", 64'(cdb.tag), 64'(LD_1));
        check("flush_full", 64'(bfull), 64'(0));
        tick();
        check("flush_after", 64'(cdb.tag), 64'(NO_VAL));

        // Asynchronous reset between edges
        offer(0, ALU_4, 32'd20);
        offer(1, LD_2, 32'd21);
        tick();
        idle_inputs();
        tick();
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_cdb_tag", 64'(cdb.tag), 64'(NO_VAL));
        check("arst_cdb_val", 64'(cdb.val), 64'(0));
        check("arst_full", 64'(bfull), 64'(0));
        m_reset();
        tick();
        reset_i = 1'b0;
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 99) < 60);
                req_tag[i]   = rs_tag_t'($urandom_range(0, 10));
                req_val[i]   = $urandom;
            end
            flush_i = ($urandom_range(0, 39) == 0);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < N + 1; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
